// File: rtl/cg_pkg.sv
// cg_pkg: constants, sub-block running-disparity rule and the RD-/RD+ valid
//    code-group tables for the 8B/10B lane checker.
// Latency: n/a (package). Backpressure: n/a.
// Bit order of a code group: bit 9 = a ... bit 0 = j (abcdei fghj).
package cg_pkg;

   localparam int CG_W = 10;

   localparam logic [CG_W-1:0] K28_5_RDN = 10'b0011111010;
   localparam logic [CG_W-1:0] K28_5_RDP = 10'b1100000101;

   // Comma pattern is the first seven bits (abcdeif) of either K28.5 column.
   localparam logic [6:0] COMMA_RDN = K28_5_RDN[9:3];
   localparam logic [6:0] COMMA_RDP = K28_5_RDP[9:3];

   // 5b/6b sub-block codes (abcdei), RD- column, indexed by EDCBA.
   // The RD+ column is the complement for unbalanced codes and for D.7.
   localparam logic [5:0] T6_RDN [32] = '{
      6'b100111, 6'b011101, 6'b101101, 6'b110001, 6'b110101, 6'b101001, 6'b011001, 6'b111000,
      6'b111001, 6'b100101, 6'b010101, 6'b110100, 6'b001101, 6'b101100, 6'b011100, 6'b010111,
      6'b011011, 6'b100011, 6'b010011, 6'b110010, 6'b001011, 6'b101010, 6'b011010, 6'b111010,
      6'b110011, 6'b100110, 6'b010110, 6'b110110, 6'b001110, 6'b101110, 6'b011110, 6'b101011
   };

   // 3b/4b sub-block codes (fghj), RD- column, indexed by HGF (index 7 = P7).
   localparam logic [3:0] T4_RDN [8] = '{
      4'b1011, 4'b1001, 4'b0101, 4'b1100, 4'b1101, 4'b1010, 4'b0110, 4'b1110
   };

   // The 12 special code groups, RD- column; RD+ column is the full complement.
   localparam logic [CG_W-1:0] K_RDN [12] = '{
      10'b0011110100, 10'b0011111001, 10'b0011110101, 10'b0011110011,
      10'b0011110010, K28_5_RDN,      10'b0011110110, 10'b0011111000,
      10'b1110101000, 10'b1101101000, 10'b1011101000, 10'b0111101000
   };

   // Running disparity at the end of one sub-block. For the 4b case only
   // sb[3:0] is looked at.
   function automatic logic sub_rd(input logic [5:0] sb, input logic is_6b,
                                   input logic rd_in);
      int   ones;
      logic res;
      res = rd_in;
      if (is_6b) begin
         ones = $countones(sb);
         if (ones > 3 || sb == 6'b000111)      res = 1'b1;
         else if (ones < 3 || sb == 6'b111000) res = 1'b0;
      end else begin
         ones = $countones(sb[3:0]);
         if (ones > 2 || sb[3:0] == 4'b0011)      res = 1'b1;
         else if (ones < 2 || sb[3:0] == 4'b1100) res = 1'b0;
      end
      return res;
   endfunction

   // Encodes one data octet for the given entering RD.
   function automatic logic [CG_W-1:0] enc_d(input logic [7:0] octet, input logic rd_in);
      logic [4:0] x;
      logic [2:0] y;
      logic [5:0] s6;
      logic [3:0] s4;
      logic       rd_mid;
      logic       use_a7;
      x  = octet[4:0];
      y  = octet[7:5];
      s6 = T6_RDN[x];
      if (rd_in && ($countones(s6) != 3 || s6 == 6'b111000)) s6 = ~s6;
      rd_mid = sub_rd(s6, 1'b1, rd_in);
      // Alternate x.7 encoding avoids a run of five equal bits across the boundary.
      use_a7 = (y == 3'd7) &&
               ((!rd_mid && (x == 5'd17 || x == 5'd18 || x == 5'd20)) ||
                ( rd_mid && (x == 5'd11 || x == 5'd13 || x == 5'd14)));
      s4 = use_a7 ? 4'b0111 : T4_RDN[y];
      if (rd_mid && ($countones(s4) != 2 || s4 == 4'b1100)) s4 = ~s4;
      return {s6, s4};
   endfunction

   function automatic logic [1023:0] build_valid(input logic rd_in);
      logic [1023:0]   tbl;
      logic [CG_W-1:0] cw;
      tbl = '0;
      for (int i = 0; i < 256; i++) begin
         cw = enc_d(8'(i), rd_in);
         tbl[cw] = 1'b1;
      end
      for (int k = 0; k < 12; k++) begin
         cw = rd_in ? ~K_RDN[k] : K_RDN[k];
         tbl[cw] = 1'b1;
      end
      return tbl;
   endfunction

   // One bit per 10-bit value: set when the value is a legal code group.
   localparam logic [1023:0] VALID_RDN = build_valid(1'b0);
   localparam logic [1023:0] VALID_RDP = build_valid(1'b1);

endpackage

// File: rtl/cg_lane_checker_lane.sv
// cg_lane_check: one lane of the code-group checker (table lookup, RD register,
//    comma detect, saturating error counter). Latency 1 cycle; no backpressure.
// Ports: clk, reset (sync, high), valid, code_group[9:0], clr_cnt -> cg, invalid,
//    comma, rd, err_cnt. Counter is built only when CG_ERR_CNT_EN is defined.
module cg_lane_check import cg_pkg::*; #(
   parameter int CNT_W = 8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             valid,
   input  logic [CG_W-1:0]  code_group,
   input  logic             clr_cnt,
   output logic [CG_W-1:0]  cg,
   output logic             invalid,
   output logic             comma,
   output logic             rd,
   output logic [CNT_W-1:0] err_cnt
);

   logic in_table;
   logic comma_now;
   logic rd_mid;
   logic rd_next;

   // rd is the registered RD after the previous group, i.e. the RD this group
   // is checked against. RD advances even for groups not in the table.
   always_comb begin
      in_table  = rd ? VALID_RDP[code_group] : VALID_RDN[code_group];
      comma_now = (code_group[9:3] == COMMA_RDN) || (code_group[9:3] == COMMA_RDP);
      rd_mid    = sub_rd(code_group[9:4], 1'b1, rd);
      rd_next   = sub_rd({2'b00, code_group[3:0]}, 1'b0, rd_mid);
   end

   // cg and rd hold through idle cycles; the per-group flags read as 0.
   always_ff @(posedge clk) begin
      if (reset) begin
         cg      <= '0;
         invalid <= 1'b0;
         comma   <= 1'b0;
         rd      <= 1'b0;
      end else if (valid) begin
         cg      <= code_group;
         invalid <= ~in_table;
         comma   <= comma_now;
         rd      <= rd_next;
      end else begin
         invalid <= 1'b0;
         comma   <= 1'b0;
      end
   end

`ifdef CG_ERR_CNT_EN
   // Clear wins over a coincident error; the count sticks at all-ones.
   always_ff @(posedge clk) begin
      if (reset) begin
         err_cnt <= '0;
      end else if (clr_cnt) begin
         err_cnt <= '0;
      end else if (valid && !in_table && err_cnt != {CNT_W{1'b1}}) begin
         err_cnt <= err_cnt + 1'b1;
      end
   end
`else
   logic unused_clr;
   assign unused_clr = clr_cnt;
   assign err_cnt    = '0;
`endif

endmodule

// File: rtl/cg_lane_checker.sv
// cg_lane_checker: multi-lane 8B/10B code-group validity / RD / comma checker.
//    Latency 1 cycle; a group is accepted every cycle, no backpressure.
// Ports: clk, reset (sync, high), cg_valid_in, code_group[LANES*10], clr_cnt ->
//    cg_valid_out, cg_out, cg_invalid, cg_comma, rd_out, err_cnt[LANES*CNT_W].
//    Error counters exist only when CG_ERR_CNT_EN is defined; otherwise err_cnt = 0.
module cg_lane_checker import cg_pkg::*; #(
   parameter int LANES = 1,
   parameter int CNT_W = 8
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   cg_valid_in,
   input  logic [LANES*CG_W-1:0]  code_group,
   input  logic                   clr_cnt,
   output logic                   cg_valid_out,
   output logic [LANES*CG_W-1:0]  cg_out,
   output logic [LANES-1:0]       cg_invalid,
   output logic [LANES-1:0]       cg_comma,
   output logic [LANES-1:0]       rd_out,
   output logic [LANES*CNT_W-1:0] err_cnt
);

   always_ff @(posedge clk) begin
      if (reset) cg_valid_out <= 1'b0;
      else       cg_valid_out <= cg_valid_in;
   end

   for (genvar n = 0; n < LANES; n++) begin : g_lane
      cg_lane_check #(
         .CNT_W (CNT_W)
      ) u_lane (
         .clk        (clk),
         .reset      (reset),
         .valid      (cg_valid_in),
         .code_group (code_group[n*CG_W +: CG_W]),
         .clr_cnt    (clr_cnt),
         .cg         (cg_out[n*CG_W +: CG_W]),
         .invalid    (cg_invalid[n]),
         .comma      (cg_comma[n]),
         .rd         (rd_out[n]),
         .err_cnt    (err_cnt[n*CNT_W +: CNT_W])
      );
   end

endmodule

// File: tb/tb_cg_lane_checker.sv
// Testbench for cg_lane_checker (LANES = 4, CNT_W = 8).
module tb_cg_lane_checker;

   localparam int LANES = 4;
   localparam int CNT_W = 8;
   localparam int CMAX  = (1 << CNT_W) - 1;
   localparam logic [9:0] K28N = 10'b0011111010;
   localparam logic [9:0] K28P = 10'b1100000101;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic                   reset, cg_valid_in, clr_cnt;
   logic [LANES*10-1:0]    code_group, cg_out;
   logic                   cg_valid_out;
   logic [LANES-1:0]       cg_invalid, cg_comma, rd_out;
   logic [LANES*CNT_W-1:0] err_cnt;

   cg_lane_checker #(.LANES(LANES), .CNT_W(CNT_W)) dut (
      .clk          (clk),
      .reset        (reset),
      .cg_valid_in  (cg_valid_in),
      .code_group   (code_group),
      .clr_cnt      (clr_cnt),
      .cg_valid_out (cg_valid_out),
      .cg_out       (cg_out),
      .cg_invalid   (cg_invalid),
      .cg_comma     (cg_comma),
      .rd_out       (rd_out),
      .err_cnt      (err_cnt)
   );

   int n_vec = 0;
   int n_err = 0;

   // Both columns written out in full, straight from the code tables.
   localparam logic [5:0] S6N [32] = '{
      6'b100111, 6'b011101, 6'b101101, 6'b110001, 6'b110101, 6'b101001, 6'b011001, 6'b111000,
      6'b111001, 6'b100101, 6'b010101, 6'b110100, 6'b001101, 6'b101100, 6'b011100, 6'b010111,
      6'b011011, 6'b100011, 6'b010011, 6'b110010, 6'b001011, 6'b101010, 6'b011010, 6'b111010,
      6'b110011, 6'b100110, 6'b010110, 6'b110110, 6'b001110, 6'b101110, 6'b011110, 6'b101011};
   localparam logic [5:0] S6P [32] = '{
      6'b011000, 6'b100010, 6'b010010, 6'b110001, 6'b001010, 6'b101001, 6'b011001, 6'b000111,
      6'b000110, 6'b100101, 6'b010101, 6'b110100, 6'b001101, 6'b101100, 6'b011100, 6'b101000,
      6'b100100, 6'b100011, 6'b010011, 6'b110010, 6'b001011, 6'b101010, 6'b011010, 6'b000101,
      6'b001100, 6'b100110, 6'b010110, 6'b001001, 6'b001110, 6'b010001, 6'b100001, 6'b010100};
   localparam logic [3:0] S4N [8] = '{4'b1011, 4'b1001, 4'b0101, 4'b1100, 4'b1101, 4'b1010, 4'b0110, 4'b1110};
   localparam logic [3:0] S4P [8] = '{4'b0100, 4'b1001, 4'b0101, 4'b0011, 4'b0010, 4'b1010, 4'b0110, 4'b0001};
   localparam logic [9:0] KN [12] = '{
      10'b0011110100, 10'b0011111001, 10'b0011110101, 10'b0011110011, 10'b0011110010, 10'b0011111010,
      10'b0011110110, 10'b0011111000, 10'b1110101000, 10'b1101101000, 10'b1011101000, 10'b0111101000};
   localparam logic [9:0] KP [12] = '{
      10'b1100001011, 10'b1100000110, 10'b1100001010, 10'b1100001100, 10'b1100001101, 10'b1100000101,
      10'b1100001001, 10'b1100000111, 10'b0001010111, 10'b0010010111, 10'b0100010111, 10'b1000010111};

   bit         valid_tab [2][1024];
   logic [9:0] code_n[$];
   logic [9:0] code_p[$];

   // Reference model state.
   int                  m_rd  [LANES];
   int                  m_cnt [LANES];
   logic                e_vld;
   logic [LANES*10-1:0] e_cg;
   logic [LANES-1:0]    e_inv, e_comma, e_rd;

   // RD after a whole group: disparity of each sub-block from its ones count.
   function automatic int rd_after(input logic [9:0] c, input int rd);
      int r, d6, d4;
      r  = rd;
      d6 = 2 * $countones(c[9:4]) - 6;
      if (d6 > 0 || c[9:4] == 6'b000111)      r = 1;
      else if (d6 < 0 || c[9:4] == 6'b111000) r = 0;
      d4 = 2 * $countones(c[3:0]) - 4;
      if (d4 > 0 || c[3:0] == 4'b0011)      r = 1;
      else if (d4 < 0 || c[3:0] == 4'b1100) r = 0;
      return r;
   endfunction

   function automatic int cnt_exp(input int v);
`ifdef CG_ERR_CNT_EN
      return v;
`else
      return v * 0;
`endif
   endfunction

   task automatic build_tables();
      logic [5:0] s6;
      logic [3:0] s4;
      int         mid;
      bit         alt;
      for (int rd = 0; rd < 2; rd++) begin
         for (int x = 0; x < 32; x++) begin
            for (int y = 0; y < 8; y++) begin
               s6  = (rd == 1) ? S6P[x] : S6N[x];
               mid = rd_after({s6, 4'b0101}, rd);
               alt = (y == 7) && ((mid == 0 && (x == 17 || x == 18 || x == 20)) ||
                                  (mid == 1 && (x == 11 || x == 13 || x == 14)));
               if (alt) s4 = (mid == 1) ? 4'b1000 : 4'b0111;
               else     s4 = (mid == 1) ? S4P[y] : S4N[y];
               valid_tab[rd][{s6, s4}] = 1'b1;
            end
         end
      end
      for (int k = 0; k < 12; k++) begin
         valid_tab[0][KN[k]] = 1'b1;
         valid_tab[1][KP[k]] = 1'b1;
      end
      for (int v = 0; v < 1024; v++) begin
         if (valid_tab[0][v]) code_n.push_back(10'(v));
         if (valid_tab[1][v]) code_p.push_back(10'(v));
      end
   endtask

   // Drives one cycle and advances the reference model across the edge.
   task automatic tick(input logic rst, input logic vld, input logic [LANES*10-1:0] cg,
                       input logic clr);
      logic [9:0] c;
      reset = rst; cg_valid_in = vld; code_group = cg; clr_cnt = clr;
      @(posedge clk);
      if (rst) begin
         e_vld = 1'b0; e_cg = '0; e_inv = '0; e_comma = '0; e_rd = '0;
         for (int l = 0; l < LANES; l++) begin m_rd[l] = 0; m_cnt[l] = 0; end
      end else begin
         e_vld = vld;
         for (int l = 0; l < LANES; l++) begin
            if (vld) begin
               c  = cg[l*10 +: 10];
               e_inv[l]   = !valid_tab[m_rd[l]][c];
               e_comma[l] = (c[9:3] == 7'b0011111) || (c[9:3] == 7'b1100000);
               m_rd[l]    = rd_after(c, m_rd[l]);
               e_rd[l]    = (m_rd[l] == 1);
               e_cg[l*10 +: 10] = c;
            end else begin
               e_inv[l] = 1'b0; e_comma[l] = 1'b0;
            end
            if (clr) m_cnt[l] = 0;
            else if (vld && e_inv[l] && m_cnt[l] < CMAX) m_cnt[l]++;
         end
      end
      #1;
   endtask

   task automatic test_reset();
      tick(1'b1, 1'b0, '0, 1'b0);
      tick(1'b1, 1'b0, '0, 1'b0);
      n_vec++; if (cg_valid_out !== 1'b0) begin n_err++; $display("FAIL reset_vld got %b want 0", cg_valid_out); end
      n_vec++; if (cg_out !== '0) begin n_err++; $display("FAIL reset_cg got %h want 0", cg_out); end
      n_vec++; if (cg_invalid !== '0) begin n_err++; $display("FAIL reset_inv got %b want 0", cg_invalid); end
      n_vec++; if (cg_comma !== '0) begin n_err++; $display("FAIL reset_comma got %b want 0", cg_comma); end
      n_vec++; if (rd_out !== '0) begin n_err++; $display("FAIL reset_rd got %b want 0", rd_out); end
      n_vec++; if (err_cnt !== '0) begin n_err++; $display("FAIL reset_cnt got %h want 0", err_cnt); end
   endtask

   task automatic test_comma_flip();
      tick(1'b1, 1'b0, '0, 1'b0);
      tick(1'b0, 1'b1, {LANES{K28N}}, 1'b0);
      n_vec++; if (cg_valid_out !== 1'b1) begin n_err++; $display("FAIL k28n_vld got %b want 1", cg_valid_out); end
      n_vec++; if (cg_out[9:0] !== K28N) begin n_err++; $display("FAIL k28n_cg got %b want %b", cg_out[9:0], K28N); end
      n_vec++; if (cg_invalid[0] !== 1'b0) begin n_err++; $display("FAIL k28n_inv got %b want 0", cg_invalid[0]); end
      n_vec++; if (cg_comma[0] !== 1'b1) begin n_err++; $display("FAIL k28n_comma got %b want 1", cg_comma[0]); end
      n_vec++; if (rd_out[0] !== 1'b1) begin n_err++; $display("FAIL k28n_rd got %b want 1", rd_out[0]); end
      n_vec++; if (err_cnt[CNT_W-1:0] !== '0) begin n_err++; $display("FAIL k28n_cnt got %0d want 0", err_cnt[CNT_W-1:0]); end
      tick(1'b0, 1'b1, {LANES{K28P}}, 1'b0);
      n_vec++; if (cg_invalid[0] !== 1'b0) begin n_err++; $display("FAIL k28p_inv got %b want 0", cg_invalid[0]); end
      n_vec++; if (cg_comma[0] !== 1'b1) begin n_err++; $display("FAIL k28p_comma got %b want 1", cg_comma[0]); end
      n_vec++; if (rd_out[0] !== 1'b0) begin n_err++; $display("FAIL k28p_rd got %b want 0", rd_out[0]); end
   endtask

   task automatic test_wrong_disparity();
      tick(1'b1, 1'b0, '0, 1'b0);
      tick(1'b0, 1'b1, {LANES{K28P}}, 1'b0);
      n_vec++; if (cg_invalid[0] !== 1'b1) begin n_err++; $display("FAIL wrongrd_inv got %b want 1", cg_invalid[0]); end
      n_vec++; if (cg_comma[0] !== 1'b1) begin n_err++; $display("FAIL wrongrd_comma got %b want 1", cg_comma[0]); end
      n_vec++; if (int'(err_cnt[CNT_W-1:0]) !== cnt_exp(1)) begin n_err++; $display("FAIL wrongrd_cnt got %0d want %0d", err_cnt[CNT_W-1:0], cnt_exp(1)); end
      n_vec++; if (rd_out[0] !== 1'b0) begin n_err++; $display("FAIL wrongrd_rd got %b want 0", rd_out[0]); end
   endtask

   task automatic test_saturation();
      tick(1'b1, 1'b0, '0, 1'b0);
      repeat (300) tick(1'b0, 1'b1, '0, 1'b0);
      for (int l = 0; l < LANES; l++) begin
         n_vec++; if (int'(err_cnt[l*CNT_W +: CNT_W]) !== cnt_exp(CMAX)) begin n_err++; $display("FAIL sat_cnt lane %0d got %0d want %0d", l, err_cnt[l*CNT_W +: CNT_W], cnt_exp(CMAX)); end
      end
      n_vec++; if (cg_invalid !== {LANES{1'b1}}) begin n_err++; $display("FAIL sat_inv got %b want all 1", cg_invalid); end
      tick(1'b0, 1'b1, '0, 1'b1);
      n_vec++; if (err_cnt !== '0) begin n_err++; $display("FAIL clr_prio got %h want 0", err_cnt); end
      tick(1'b0, 1'b1, '0, 1'b0);
      n_vec++; if (int'(err_cnt[CNT_W-1:0]) !== cnt_exp(1)) begin n_err++; $display("FAIL after_clr got %0d want %0d", err_cnt[CNT_W-1:0], cnt_exp(1)); end
   endtask

   task automatic test_idle_hold();
      tick(1'b1, 1'b0, '0, 1'b0);
      tick(1'b0, 1'b1, {LANES{K28N}}, 1'b0);
      tick(1'b0, 1'b1, {LANES{K28N}}, 1'b0);   // wrong column at RD+, RD stays +
      n_vec++; if (cg_invalid !== {LANES{1'b1}} || rd_out !== {LANES{1'b1}}) begin n_err++; $display("FAIL idle_pre got inv %b rd %b want 1111 1111", cg_invalid, rd_out); end
      for (int i = 0; i < 5; i++) begin
         tick(1'b0, 1'b0, {LANES{10'($urandom_range(0, 1023))}}, 1'b0);
         n_vec++; if (cg_valid_out !== 1'b0) begin n_err++; $display("FAIL idle_vld got %b want 0", cg_valid_out); end
         n_vec++; if (cg_invalid !== '0 || cg_comma !== '0) begin n_err++; $display("FAIL idle_flags got %b %b want 0 0", cg_invalid, cg_comma); end
         n_vec++; if (rd_out !== {LANES{1'b1}}) begin n_err++; $display("FAIL idle_rd got %b want 1111", rd_out); end
         n_vec++; if (cg_out !== {LANES{K28N}}) begin n_err++; $display("FAIL idle_cg got %h want %h", cg_out, {LANES{K28N}}); end
         n_vec++; if (int'(err_cnt[CNT_W-1:0]) !== cnt_exp(1)) begin n_err++; $display("FAIL idle_cnt got %0d want %0d", err_cnt[CNT_W-1:0], cnt_exp(1)); end
      end
      tick(1'b0, 1'b1, {LANES{K28P}}, 1'b0);
      n_vec++; if (cg_invalid !== '0 || rd_out !== '0) begin n_err++; $display("FAIL idle_resume got inv %b rd %b want 0 0", cg_invalid, rd_out); end
   endtask

   task automatic test_lane_independence();
      tick(1'b1, 1'b0, '0, 1'b0);
      tick(1'b0, 1'b1, {K28N, 10'b0, K28N, K28N}, 1'b0);
      n_vec++; if (cg_invalid !== 4'b0100) begin n_err++; $display("FAIL lanes_inv got %b want 0100", cg_invalid); end
      for (int l = 0; l < LANES; l++) begin
         n_vec++; if (int'(err_cnt[l*CNT_W +: CNT_W]) !== cnt_exp(l == 2 ? 1 : 0)) begin n_err++; $display("FAIL lanes_cnt lane %0d got %0d want %0d", l, err_cnt[l*CNT_W +: CNT_W], cnt_exp(l == 2 ? 1 : 0)); end
      end
      n_vec++; if (rd_out !== 4'b1011) begin n_err++; $display("FAIL lanes_rd got %b want 1011", rd_out); end
   endtask

   task automatic test_mid_reset();
      tick(1'b1, 1'b0, '0, 1'b0);
      tick(1'b0, 1'b1, {LANES{K28N}}, 1'b0);
      n_vec++; if (rd_out !== {LANES{1'b1}}) begin n_err++; $display("FAIL midrst_pre got %b want 1111", rd_out); end
      tick(1'b1, 1'b1, {LANES{10'b0}}, 1'b0);
      n_vec++; if (cg_valid_out !== 1'b0 || cg_out !== '0) begin n_err++; $display("FAIL midrst_out got vld %b cg %h want 0 0", cg_valid_out, cg_out); end
      n_vec++; if (cg_invalid !== '0 || cg_comma !== '0 || rd_out !== '0) begin n_err++; $display("FAIL midrst_flags got %b %b %b want 0 0 0", cg_invalid, cg_comma, rd_out); end
      n_vec++; if (err_cnt !== '0) begin n_err++; $display("FAIL midrst_cnt got %h want 0", err_cnt); end
      tick(1'b0, 1'b1, {LANES{K28N}}, 1'b0);
      n_vec++; if (cg_invalid !== '0 || rd_out !== {LANES{1'b1}}) begin n_err++; $display("FAIL midrst_after got inv %b rd %b want 0000 1111", cg_invalid, rd_out); end
   endtask

   task automatic test_random();
      logic [LANES*10-1:0] cg;
      logic                vld, clr, rst;
      int                  r;
      for (int i = 0; i < 600; i++) begin
         rst = ($urandom_range(0, 99) == 0);
         vld = ($urandom_range(0, 9) != 0);
         clr = ($urandom_range(0, 49) == 0);
         for (int l = 0; l < LANES; l++) begin
            r = $urandom_range(0, 9);
            if (r < 6)
               cg[l*10 +: 10] = (m_rd[l] == 1) ? code_p[$urandom_range(0, code_p.size() - 1)]
                                               : code_n[$urandom_range(0, code_n.size() - 1)];
            else if (r < 7)
               cg[l*10 +: 10] = (m_rd[l] == 1) ? K28P : K28N;
            else
               cg[l*10 +: 10] = 10'($urandom_range(0, 1023));
         end
         tick(rst, vld, cg, clr);
         n_vec++; if (cg_valid_out !== e_vld) begin n_err++; $display("FAIL rnd_vld cyc %0d got %b want %b", i, cg_valid_out, e_vld); end
         n_vec++; if (cg_out !== e_cg) begin n_err++; $display("FAIL rnd_cg cyc %0d got %h want %h", i, cg_out, e_cg); end
         n_vec++; if (cg_invalid !== e_inv) begin n_err++; $display("FAIL rnd_inv cyc %0d got %b want %b", i, cg_invalid, e_inv); end
         n_vec++; if (cg_comma !== e_comma) begin n_err++; $display("FAIL rnd_comma cyc %0d got %b want %b", i, cg_comma, e_comma); end
         n_vec++; if (rd_out !== e_rd) begin n_err++; $display("FAIL rnd_rd cyc %0d got %b want %b", i, rd_out, e_rd); end
         for (int l = 0; l < LANES; l++) begin
            n_vec++; if (int'(err_cnt[l*CNT_W +: CNT_W]) !== cnt_exp(m_cnt[l])) begin n_err++; $display("FAIL rnd_cnt cyc %0d lane %0d got %0d want %0d", i, l, err_cnt[l*CNT_W +: CNT_W], cnt_exp(m_cnt[l])); end
         end
      end
   endtask

   initial begin
      build_tables();
      test_reset();
      test_comma_flip();
      test_wrong_disparity();
      test_saturation();
      test_idle_hold();
      test_lane_independence();
      test_mid_reset();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
